cpu_bridge_slave_arbiter: RTL and testbench

Two-master arbiter in the slave_clk domain. It shares the single slave port of the CPU-to-peripheral clock-crossing bridge between master 0 (CPU data master) and master 1 (DMA/audio engine). Command arbitration is round-robin. The block records the requester ID of every accepted read in an in-order tag FIFO, so that bridge read responses are returned to the correct master. Reads in flight are bounded to protect the bridge response FIFO.

---
 rtl/cpu_bridge_pkg.sv | 20 ++
 rtl/cpu_bridge_tag_fifo.sv | 55 +++++
 rtl/cpu_bridge_slave_arbiter.sv | 148 ++++++++++++++
 tb/tb_cpu_bridge_slave_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bridge_pkg.sv
// Shared widths, master IDs and command bundle
// for the slave side of the CPU-to-peripheral bridge.
package cpu_bridge_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   localparam logic MST_CPU = 1'b0;
   localparam logic MST_DMA = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] address;
      logic [BE_W-1:0]   byteenable;
      logic              read;
      logic              write;
      logic [DATA_W-1:0] writedata;
   } av_cmd_t;

endpackage

// File: rtl/cpu_bridge_tag_fifo.sv
// In-order FIFO of requester IDs for reads that the
// bridge has accepted but not yet answered.
module cpu_bridge_tag_fifo
   import cpu_bridge_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             slave_clk,
   input  logic             slave_reset_n,
   input  logic             push,
   input  logic             push_id,
   input  logic             pop,
   output logic             head,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0] tags;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign head    = tags[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge slave_clk or negedge slave_reset_n) begin
      if (!slave_reset_n) begin
         tags   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            tags[wr_ptr] <= push_id;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/cpu_bridge_slave_arbiter.sv
// Round-robin arbiter sharing the bridge slave port
// between the CPU data master and the DMA engine.
module cpu_bridge_slave_arbiter
   import cpu_bridge_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 32,
   parameter int BE_W        = 4,
   parameter int MAX_PENDING = 16,
   parameter int CNT_W       = 5
) (
   input  logic              slave_clk,
   input  logic              slave_reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic              m0_readdatavalid,
   output logic              m0_endofpacket,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic              m1_readdatavalid,
   output logic              m1_endofpacket,
   output logic [DATA_W-1:0] m_readdata,
   output logic [ADDR_W-1:0] br_address,
   output logic [BE_W-1:0]   br_byteenable,
   output logic              br_read,
   output logic              br_write,
   output logic [DATA_W-1:0] br_writedata,
   input  logic              br_waitrequest,
   input  logic [DATA_W-1:0] br_readdata,
   input  logic              br_readdatavalid,
   input  logic              br_endofpacket,
   output logic [CNT_W-1:0]  pending_count,
   output logic              proto_error
);

   logic rr_last;
   logic lock;
   logic lock_id;
   logic rd_ok;
   logic elig0;
   logic elig1;
   logic gnt_vld;
   logic gnt_id;
   logic sel_rd;
   logic sel_wr;
   logic accept;
   logic push;
   logic pop;
   logic fifo_head;
   logic fifo_empty;
   logic fifo_full;

   // Registered count: a pop this cycle frees a slot next cycle.
   assign rd_ok = ~fifo_full;
   assign elig0 = m0_read ? rd_ok : m0_write;
   assign elig1 = m1_read ? rd_ok : m1_write;

   // Grant: stalled command holds, else round-robin.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = MST_CPU;
      if (lock) begin
         gnt_id  = lock_id;
         gnt_vld = lock_id ? elig1 : elig0;
      end else if (elig0 && elig1) begin
         gnt_id  = ~rr_last;
         gnt_vld = 1'b1;
      end else if (elig1) begin
         gnt_id  = MST_DMA;
         gnt_vld = 1'b1;
      end else if (elig0) begin
         gnt_id  = MST_CPU;
         gnt_vld = 1'b1;
      end
      if (!slave_reset_n)
         gnt_vld = 1'b0;
   end

   assign sel_rd = gnt_id ? m1_read  : m0_read;
   assign sel_wr = gnt_id ? m1_write : m0_write;

   assign br_read       = gnt_vld & sel_rd;
   assign br_write      = gnt_vld & sel_wr & ~sel_rd;
   assign br_address    = gnt_id ? m1_address    : m0_address;
   assign br_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
   assign br_writedata  = gnt_id ? m1_writedata  : m0_writedata;

   assign accept = gnt_vld & ~br_waitrequest;
   assign m0_waitrequest = ~(accept & (gnt_id == MST_CPU));
   assign m1_waitrequest = ~(accept & (gnt_id == MST_DMA));

   assign push = accept & sel_rd;
   assign pop  = br_readdatavalid & ~fifo_empty;

   assign m0_readdatavalid = pop & (fifo_head == MST_CPU);
   assign m1_readdatavalid = pop & (fifo_head == MST_DMA);
   assign m0_endofpacket   = m0_readdatavalid & br_endofpacket;
   assign m1_endofpacket   = m1_readdatavalid & br_endofpacket;
   assign m_readdata       = br_readdata;

   // Round-robin pointer and stall lock.
   always_ff @(posedge slave_clk or negedge slave_reset_n) begin
      if (!slave_reset_n) begin
         rr_last <= MST_DMA;
         lock    <= 1'b0;
         lock_id <= MST_CPU;
      end else if (accept) begin
         rr_last <= gnt_id;
         lock    <= 1'b0;
      end else if (gnt_vld) begin
         lock    <= 1'b1;
         lock_id <= gnt_id;
      end
   end

   // Sticky flag: read+write together, or orphan response.
   always_ff @(posedge slave_clk or negedge slave_reset_n) begin
      if (!slave_reset_n)
         proto_error <= 1'b0;
      else if ((accept & sel_rd & sel_wr) |
               (br_readdatavalid & fifo_empty))
         proto_error <= 1'b1;
   end

   cpu_bridge_tag_fifo #(
      .DEPTH (MAX_PENDING),
      .CNT_W (CNT_W)
   ) u_tag_fifo (
      .slave_clk     (slave_clk),
      .slave_reset_n (slave_reset_n),
      .push          (push),
      .push_id       (gnt_id),
      .pop           (pop),
      .head          (fifo_head),
      .empty         (fifo_empty),
      .full          (fifo_full),
      .count         (pending_count)
   );

endmodule

// File: tb/tb_cpu_bridge_slave_arbiter.sv
// Bench for the bridge slave arbiter: vector table
// plus directed multi-cycle sequences.
module tb_cpu_bridge_slave_arbiter;
   import cpu_bridge_pkg::*;

   localparam int MAXP = 16;
   localparam int CW   = 5;

   typedef struct {
      av_cmd_t     c0;
      av_cmd_t     c1;
      logic        bw;
      logic        e_rd;
      logic        e_wr;
      logic [6:0]  e_addr;
      logic [31:0] e_data;
      logic        e_w0;
      logic        e_w1;
      logic        chk_bus;
   } vec_t;

   logic        slave_clk = 1'b0;
   logic        slave_reset_n;
   av_cmd_t     c0;
   av_cmd_t     c1;
   logic        br_waitrequest;
   logic [31:0] br_readdata;
   logic        br_readdatavalid;
   logic        br_endofpacket;
   logic        m0_waitrequest;
   logic        m0_readdatavalid;
   logic        m0_endofpacket;
   logic        m1_waitrequest;
   logic        m1_readdatavalid;
   logic        m1_endofpacket;
   logic [31:0] m_readdata;
   logic [6:0]  br_address;
   logic [3:0]  br_byteenable;
   logic        br_read;
   logic        br_write;
   logic [31:0] br_writedata;
   logic [CW-1:0] pending_count;
   logic        proto_error;

   int   checks = 0;
   int   errors = 0;
   bit   exp_q[$];
   vec_t tbl[$];

   always #5 slave_clk = ~slave_clk;

   cpu_bridge_slave_arbiter #(
      .ADDR_W (7), .DATA_W (32), .BE_W (4),
      .MAX_PENDING (MAXP), .CNT_W (CW)
   ) dut (
      .slave_clk        (slave_clk),
      .slave_reset_n    (slave_reset_n),
      .m0_address       (c0.address),
      .m0_byteenable    (c0.byteenable),
      .m0_read          (c0.read),
      .m0_write         (c0.write),
      .m0_writedata     (c0.writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdatavalid (m0_readdatavalid),
      .m0_endofpacket   (m0_endofpacket),
      .m1_address       (c1.address),
      .m1_byteenable    (c1.byteenable),
      .m1_read          (c1.read),
      .m1_write         (c1.write),
      .m1_writedata     (c1.writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdatavalid (m1_readdatavalid),
      .m1_endofpacket   (m1_endofpacket),
      .m_readdata       (m_readdata),
      .br_address       (br_address),
      .br_byteenable    (br_byteenable),
      .br_read          (br_read),
      .br_write         (br_write),
      .br_writedata     (br_writedata),
      .br_waitrequest   (br_waitrequest),
      .br_readdata      (br_readdata),
      .br_readdatavalid (br_readdatavalid),
      .br_endofpacket   (br_endofpacket),
      .pending_count    (pending_count),
      .proto_error      (proto_error)
   );

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge slave_clk);
      #1;
   endtask

   function automatic av_cmd_t idle();
      av_cmd_t c;
      c = '0;
      return c;
   endfunction

   function automatic av_cmd_t wr(input logic [6:0] a,
                                  input logic [31:0] d);
      av_cmd_t c;
      c = '0;
      c.address    = a;
      c.byteenable = 4'hF;
      c.write      = 1'b1;
      c.writedata  = d;
      return c;
   endfunction

   function automatic av_cmd_t rd(input logic [6:0] a);
      av_cmd_t c;
      c = '0;
      c.address    = a;
      c.byteenable = 4'hF;
      c.read       = 1'b1;
      return c;
   endfunction

   task automatic do_reset();
      slave_reset_n    = 1'b0;
      c0               = idle();
      c1               = idle();
      br_waitrequest   = 1'b0;
      br_readdatavalid = 1'b0;
      br_endofpacket   = 1'b0;
      br_readdata      = '0;
      exp_q.delete();
      repeat (2) @(posedge slave_clk);
      @(negedge slave_clk);
      slave_reset_n = 1'b1;
      cyc();
   endtask

   // Drive one response; expected routing from the scoreboard.
   task automatic resp_chk(input logic [31:0] d,
                           input logic eop);
      bit has;
      bit id;
      has = (exp_q.size() != 0);
      id  = 1'b0;
      if (has)
         id = exp_q.pop_front();
      br_readdatavalid = 1'b1;
      br_readdata      = d;
      br_endofpacket   = eop;
      #2;
      chk("m0_rdv", m0_readdatavalid, has && id == MST_CPU);
      chk("m1_rdv", m1_readdatavalid, has && id == MST_DMA);
      chk("m0_eop", m0_endofpacket,
          has && id == MST_CPU && eop);
      chk("m1_eop", m1_endofpacket,
          has && id == MST_DMA && eop);
      chk("rdata", m_readdata, d);
   endtask

   task automatic resp(input logic [31:0] d, input logic eop);
      resp_chk(d, eop);
      cyc();
      br_readdatavalid = 1'b0;
      br_endofpacket   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      slave_reset_n    = 1'b0;
      c0               = idle();
      c1               = idle();
      br_waitrequest   = 1'b0;
      br_readdatavalid = 1'b0;
      br_endofpacket   = 1'b0;
      br_readdata      = '0;
      #13;
      chk("rst br_read", br_read, 0);
      chk("rst br_write", br_write, 0);
      chk("rst m0_wait", m0_waitrequest, 1);
      chk("rst m1_wait", m1_waitrequest, 1);
      chk("rst m0_rdv", m0_readdatavalid, 0);
      chk("rst pending", pending_count, 0);
      chk("rst proto", proto_error, 0);
      @(negedge slave_clk);
      slave_reset_n = 1'b1;
      cyc();

      // Single read and its response
      c0 = rd(7'h10);
      #2;
      chk("t1 br_read", br_read, 1);
      chk("t1 br_addr", br_address, 7'h10);
      chk("t1 m0_wait", m0_waitrequest, 0);
      exp_q.push_back(MST_CPU);
      cyc();
      c0 = idle();
      #2;
      chk("t1 pending1", pending_count, 1);
      resp(32'hCAFE0001, 1'b1);
      #2;
      chk("t1 pending0", pending_count, 0);

      // Vector table: alternation then stalled write
      tbl.push_back('{wr(7'h01, 32'hA000_0000),
                      wr(7'h02, 32'hB000_0000), 1'b0,
                      1'b0, 1'b1, 7'h01, 32'hA000_0000,
                      1'b0, 1'b1, 1'b1});
      tbl.push_back('{wr(7'h03, 32'hA000_0001),
                      wr(7'h02, 32'hB000_0000), 1'b0,
                      1'b0, 1'b1, 7'h02, 32'hB000_0000,
                      1'b1, 1'b0, 1'b1});
      tbl.push_back('{wr(7'h03, 32'hA000_0001),
                      wr(7'h04, 32'hB000_0001), 1'b0,
                      1'b0, 1'b1, 7'h03, 32'hA000_0001,
                      1'b0, 1'b1, 1'b1});
      tbl.push_back('{wr(7'h05, 32'hA000_0002),
                      wr(7'h04, 32'hB000_0001), 1'b0,
                      1'b0, 1'b1, 7'h04, 32'hB000_0001,
                      1'b1, 1'b0, 1'b1});
      tbl.push_back('{idle(),
                      wr(7'h22, 32'hB000_0002), 1'b1,
                      1'b0, 1'b1, 7'h22, 32'hB000_0002,
                      1'b1, 1'b1, 1'b1});
      for (int k = 0; k < 2; k++)
         tbl.push_back('{wr(7'h05, 32'hA000_0002),
                         wr(7'h22, 32'hB000_0002), 1'b1,
                         1'b0, 1'b1, 7'h22, 32'hB000_0002,
                         1'b1, 1'b1, 1'b1});
      tbl.push_back('{wr(7'h05, 32'hA000_0002),
                      wr(7'h22, 32'hB000_0002), 1'b0,
                      1'b0, 1'b1, 7'h22, 32'hB000_0002,
                      1'b1, 1'b0, 1'b1});
      tbl.push_back('{wr(7'h05, 32'hA000_0002),
                      wr(7'h23, 32'hB000_0003), 1'b0,
                      1'b0, 1'b1, 7'h05, 32'hA000_0002,
                      1'b0, 1'b1, 1'b1});
      tbl.push_back('{idle(),
                      wr(7'h23, 32'hB000_0003), 1'b0,
                      1'b0, 1'b1, 7'h23, 32'hB000_0003,
                      1'b1, 1'b0, 1'b1});
      tbl.push_back('{idle(), idle(), 1'b0,
                      1'b0, 1'b0, 7'h00, 32'h0,
                      1'b1, 1'b1, 1'b0});

      do_reset();
      foreach (tbl[i]) begin
         c0             = tbl[i].c0;
         c1             = tbl[i].c1;
         br_waitrequest = tbl[i].bw;
         #2;
         chk($sformatf("v%0d br_read", i), br_read, tbl[i].e_rd);
         chk($sformatf("v%0d br_write", i), br_write, tbl[i].e_wr);
         chk($sformatf("v%0d m0_wait", i), m0_waitrequest,
             tbl[i].e_w0);
         chk($sformatf("v%0d m1_wait", i), m1_waitrequest,
             tbl[i].e_w1);
         if (tbl[i].chk_bus) begin
            chk($sformatf("v%0d br_addr", i), br_address,
                tbl[i].e_addr);
            chk($sformatf("v%0d br_wdata", i), br_writedata,
                tbl[i].e_data);
         end
         cyc();
      end
      br_waitrequest = 1'b0;

      // Read throttle at MAX_PENDING
      do_reset();
      for (int i = 0; i < MAXP; i++) begin
         c0 = rd(7'(i));
         #2;
         chk($sformatf("thr acc%0d", i), m0_waitrequest, 0);
         exp_q.push_back(MST_CPU);
         cyc();
      end
      c0 = rd(7'h40);
      c1 = wr(7'h41, 32'h0000_D00D);
      #2;
      chk("thr pend full", pending_count, MAXP);
      chk("thr m0 stalled", m0_waitrequest, 1);
      chk("thr m1 write", m1_waitrequest, 0);
      chk("thr br_write", br_write, 1);
      chk("thr br_addr", br_address, 7'h41);
      cyc();
      c1 = idle();
      resp_chk(32'h1111_0000, 1'b1);
      chk("thr stall on pop", m0_waitrequest, 1);
      cyc();
      br_readdatavalid = 1'b0;
      br_endofpacket   = 1'b0;
      #2;
      chk("thr pend 15", pending_count, MAXP - 1);
      chk("thr read acc", m0_waitrequest, 0);
      exp_q.push_back(MST_CPU);
      cyc();
      c0 = idle();
      #2;
      chk("thr pend back", pending_count, MAXP);
      for (int i = 0; i < MAXP; i++)
         resp(32'h2000_0000 + 32'(i), 1'(i));
      #2;
      chk("thr drained", pending_count, 0);

      // Interleaved reads, in-order routing
      c0 = rd(7'h50);
      #2;
      chk("il m0 acc", m0_waitrequest, 0);
      exp_q.push_back(MST_CPU);
      cyc();
      c0 = idle();
      c1 = rd(7'h51);
      #2;
      chk("il m1 acc", m1_waitrequest, 0);
      exp_q.push_back(MST_DMA);
      cyc();
      c1 = idle();
      c0 = rd(7'h52);
      #2;
      chk("il m0 acc2", m0_waitrequest, 0);
      exp_q.push_back(MST_CPU);
      cyc();
      c0 = idle();
      #2;
      chk("il pend3", pending_count, 3);
      resp(32'h3000_0000, 1'b1);
      resp(32'h3000_0001, 1'b0);
      resp(32'h3000_0002, 1'b1);
      #2;
      chk("il pend0", pending_count, 0);

      // Read and write together: read only, flagged
      c1 = rd(7'h33);
      c1.write     = 1'b1;
      c1.writedata = 32'h5555_AAAA;
      #2;
      chk("rw br_read", br_read, 1);
      chk("rw br_write", br_write, 0);
      chk("rw m1_wait", m1_waitrequest, 0);
      exp_q.push_back(MST_DMA);
      cyc();
      c1 = idle();
      #2;
      chk("rw proto", proto_error, 1);
      resp(32'h4000_0000, 1'b1);

      // Orphan response
      do_reset();
      chk("orph proto0", proto_error, 0);
      resp(32'h0000_DEAD, 1'b1);
      #2;
      chk("orph proto1", proto_error, 1);
      chk("orph pending", pending_count, 0);
      repeat (3) cyc();
      chk("orph sticky", proto_error, 1);

      // Reset while a write is locked
      c0 = rd(7'h60);
      #2;
      exp_q.push_back(MST_CPU);
      cyc();
      c0 = wr(7'h61, 32'h6161_6161);
      br_waitrequest = 1'b1;
      #2;
      chk("rl br_write", br_write, 1);
      cyc();
      chk("rl pending1", pending_count, 1);
      slave_reset_n = 1'b0;
      #1;
      chk("rl br_read", br_read, 0);
      chk("rl br_write0", br_write, 0);
      chk("rl pending0", pending_count, 0);
      chk("rl m0_wait", m0_waitrequest, 1);
      exp_q.delete();
      c0 = idle();
      br_waitrequest = 1'b0;
      @(negedge slave_clk);
      slave_reset_n = 1'b1;
      cyc();
      c1 = wr(7'h62, 32'h6262_6262);
      #2;
      chk("rl unlock wr", br_write, 1);
      chk("rl unlock addr", br_address, 7'h62);
      chk("rl m1_wait", m1_waitrequest, 0);
      cyc();
      c1 = idle();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
